// File: rtl/ntt_input_packer.sv
// ntt_input_packer: packs a serial coefficient stream into 64-lane beats for NTT_Top.
// Two ping-pong polynomial buffers let one polynomial fill while the other drains as
// BEATS back-to-back beats. Output registers are loaded from the next-state view so a
// polynomial closing in cycle t can already present beat 0 in cycle t+1.
module ntt_input_packer #(
    parameter int DATA_WIDTH_PER_INPUT = 28,
    parameter int INPUT_PER_CYCLE      = 64,
    parameter int N                    = 512,
    localparam int BEATS               = N / INPUT_PER_CYCLE,
    localparam int BEAT_W              = $clog2(BEATS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] s_data,
    input  logic                            s_last,
    input  logic                            out_hold,
    output logic                            out_valid,
    output logic                            out_start,
    output logic [BEAT_W-1:0]               out_beat,
    output logic [DATA_WIDTH_PER_INPUT-1:0] out_data [INPUT_PER_CYCLE],
    output logic                            err_no_last
);

    localparam int DW     = DATA_WIDTH_PER_INPUT;
    localparam int LANE_W = $clog2(INPUT_PER_CYCLE);
    localparam int IDX_W  = $clog2(N);
    localparam int LEN_W  = IDX_W + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    // Coefficient storage, one polynomial per buffer; contents are never reset,
    // stale words are hidden by the per-buffer length mask.
    logic [DW-1:0]    mem_q [2][N];

    logic [1:0]       full_q, full_d;
    logic             wr_buf_q, wr_buf_d;
    logic             rd_buf_q, rd_buf_d;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic [LEN_W-1:0] len_q [2];
    logic [LEN_W-1:0] len_d [2];
    logic             err_q, err_d;
    state_t           state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic             out_start_q, out_start_d;
    logic [DW-1:0]    out_data_q [INPUT_PER_CYCLE];
    logic [DW-1:0]    out_data_d [INPUT_PER_CYCLE];

    logic             accept;
    logic             at_end;
    logic             close_poly;
    logic             stream_end;
    logic [IDX_W-1:0] lane_idx;

    assign s_ready     = !full_q[wr_buf_q];
    assign accept      = s_valid && s_ready;
    assign at_end      = (widx_q == IDX_W'(N - 1));
    assign close_poly  = accept && (s_last || at_end);
    assign stream_end  = (state_q == STREAM) && (beat_q == BEAT_W'(BEATS - 1));

    assign out_valid   = (state_q == STREAM);
    assign out_start   = out_start_q;
    assign out_beat    = beat_q;
    assign out_data    = out_data_q;
    assign err_no_last = err_q;

    // Store each accepted coefficient into the buffer currently being filled.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_buf_q][widx_q] <= s_data;
        end
    end

    // State register for write side, read FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= '0;
            wr_buf_q    <= 1'b0;
            rd_buf_q    <= 1'b0;
            widx_q      <= '0;
            len_q       <= '{default: '0};
            err_q       <= 1'b0;
            state_q     <= IDLE;
            beat_q      <= '0;
            out_start_q <= 1'b0;
            out_data_q  <= '{default: '0};
        end else begin
            full_q      <= full_d;
            wr_buf_q    <= wr_buf_d;
            rd_buf_q    <= rd_buf_d;
            widx_q      <= widx_d;
            len_q       <= len_d;
            err_q       <= err_d;
            state_q     <= state_d;
            beat_q      <= beat_d;
            out_start_q <= out_start_d;
            out_data_q  <= out_data_d;
        end
    end

    // Write side: advance the fill index, close a polynomial on s_last or when the buffer is full.
    always_comb begin
        widx_d   = widx_q;
        wr_buf_d = wr_buf_q;
        len_d    = len_q;
        err_d    = err_q;
        full_d   = full_q;
        if (accept) begin
            widx_d = widx_q + IDX_W'(1);
        end
        if (accept && at_end && !s_last) begin
            err_d = 1'b1;
        end
        if (stream_end) begin
            full_d[rd_buf_q] = 1'b0;
        end
        if (close_poly) begin
            widx_d           = '0;
            wr_buf_d         = ~wr_buf_q;
            len_d[wr_buf_q]  = {1'b0, widx_q} + LEN_W'(1);
            full_d[wr_buf_q] = 1'b1;
        end
    end

    // Read FSM next state: start on a full buffer unless held, chain straight into the other buffer.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        rd_buf_d = rd_buf_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (full_d[rd_buf_q] && !out_hold) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (stream_end) begin
                    rd_buf_d = ~rd_buf_q;
                    beat_d   = '0;
                    if (full_d[~rd_buf_q] && !out_hold) begin
                        state_d = STREAM;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
        endcase
    end

    // Output data for the next beat: zero past the polynomial length, bypass the word written this cycle.
    always_comb begin
        out_start_d = (state_d == STREAM) && (beat_d == '0);
        lane_idx    = '0;
        for (int l = 0; l < INPUT_PER_CYCLE; l++) begin
            out_data_d[l] = '0;
            lane_idx      = {beat_d, LANE_W'(l)};
            if ((state_d == STREAM) && ({1'b0, lane_idx} < len_d[rd_buf_d])) begin
                if (accept && (wr_buf_q == rd_buf_d) && (widx_q == lane_idx)) begin
                    out_data_d[l] = s_data;
                end else begin
                    out_data_d[l] = mem_q[rd_buf_d][lane_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_ntt_input_packer.sv
// Directed testbench for ntt_input_packer: feeds polynomials, records every output beat
// and compares against hand-derived coefficient values.
module tb_ntt_input_packer;

   localparam int DW    = 28;
   localparam int LANES = 64;
   localparam int N     = 512;
   localparam int BEATS = 8;

   logic          clk;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          out_hold;
   logic          out_valid;
   logic          out_start;
   logic [2:0]    out_beat;
   logic [DW-1:0] out_data [LANES];
   logic          err_no_last;

   int testCount  = 0;
   int failCount  = 0;
   int cycleCount = 0;

   typedef struct {
      int                    cyc;
      logic                  start;
      logic [2:0]            beat;
      logic [LANES*DW-1:0]   data;
   } beat_rec_t;

   beat_rec_t beatQ[$];

   ntt_input_packer dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .out_hold    (out_hold),
      .out_valid   (out_valid),
      .out_start   (out_start),
      .out_beat    (out_beat),
      .out_data    (out_data),
      .err_no_last (err_no_last)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to prove beats are emitted without gaps.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Record every valid output beat mid-cycle, away from the active edge.
   always @(negedge clk) begin : collector
      beat_rec_t r;
      if (out_valid === 1'b1) begin
         r.cyc   = cycleCount;
         r.start = out_start;
         r.beat  = out_beat;
         for (int l = 0; l < LANES; l++) r.data[l*DW +: DW] = out_data[l];
         beatQ.push_back(r);
      end
   end

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
      testCount++;
      if (got !== expv) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Feed count coefficients valued base+step*i; s_last on the final one when withLast is set.
   task automatic applyStimulus(input int base, input int step, input int count, input bit withLast);
      int waited;
      for (int i = 0; i < count; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(base + step * i);
         s_last  = withLast && (i == count - 1);
         waited  = 0;
         while (!s_ready && waited < 3000) begin
            tick();
            waited++;
         end
         if (!s_ready) begin
            checkOutput("readyTimeout", {31'b0, s_ready}, 32'd1);
            break;
         end
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Wait (bounded) until n beats were recorded, then confirm no extra beats follow.
   task automatic waitBeats(input int n);
      int k;
      k = 0;
      while (beatQ.size() < n && k < 300) begin
         tick();
         k++;
      end
      repeat (3) tick();
      checkOutput("beatCount", beatQ.size(), n);
   endtask

   // Check one recorded polynomial: start/beat flags, gap-free timing and lane values.
   task automatic checkPoly(input int qoff, input int base, input int step, input int len);
      beat_rec_t r;
      int        idx;
      logic [31:0] expv;
      if (beatQ.size() < qoff + BEATS) begin
         checkOutput("polyPresent", beatQ.size(), qoff + BEATS);
         return;
      end
      for (int b = 0; b < BEATS; b++) begin
         r = beatQ[qoff + b];
         checkOutput($sformatf("start[%0d]", qoff + b), {31'b0, r.start}, {31'b0, b == 0});
         checkOutput($sformatf("beat[%0d]", qoff + b), {29'b0, r.beat}, b);
         if (b > 0) checkOutput($sformatf("gap[%0d]", qoff + b), r.cyc - beatQ[qoff + b - 1].cyc, 1);
         for (int l = 0; l < LANES; l++) begin
            idx  = b * LANES + l;
            expv = (idx < len) ? 32'(DW'(base + step * idx)) : 32'd0;
            checkOutput($sformatf("lane[%0d][%0d]", qoff + b, l), {4'b0, r.data[l*DW +: DW]}, expv);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      out_hold = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      checkOutput("rstValid", {31'b0, out_valid}, 0);
      checkOutput("rstStart", {31'b0, out_start}, 0);
      checkOutput("rstBeat", {29'b0, out_beat}, 0);
      checkOutput("rstErr", {31'b0, err_no_last}, 0);
      checkOutput("rstReady", {31'b0, s_ready}, 1);
      checkOutput("rstLane0", {4'b0, out_data[0]}, 0);
      checkOutput("rstLane63", {4'b0, out_data[63]}, 0);

      // Single full polynomial 0..511, one-cycle latency to beat 0
      $display("[TB] single polynomial");
      beatQ.delete();
      applyStimulus(0, 1, N, 1'b1);
      checkOutput("latValid", {31'b0, out_valid}, 1);
      checkOutput("latStart", {31'b0, out_start}, 1);
      checkOutput("latBeat", {29'b0, out_beat}, 0);
      checkOutput("latLane5", {4'b0, out_data[5]}, 5);
      waitBeats(8);
      checkPoly(0, 0, 1, N);
      checkOutput("singleErr", {31'b0, err_no_last}, 0);

      // Short polynomial into buffers previously filled with 0x0ABCDEF
      $display("[TB] short polynomial");
      beatQ.delete();
      applyStimulus(32'h0ABCDEF, 0, N, 1'b1);
      applyStimulus(32'h0ABCDEF, 0, N, 1'b1);
      waitBeats(16);
      beatQ.delete();
      applyStimulus(1000, 1, 100, 1'b1);
      waitBeats(8);
      checkPoly(0, 1000, 1, 100);

      // Missing s_last: sticky error, polynomial still streams, next one closes correctly
      $display("[TB] missing s_last");
      beatQ.delete();
      applyStimulus(5000, 1, N, 1'b0);
      checkOutput("errSet", {31'b0, err_no_last}, 1);
      waitBeats(8);
      checkPoly(0, 5000, 1, N);
      checkOutput("errSticky", {31'b0, err_no_last}, 1);
      beatQ.delete();
      applyStimulus(7, 1, 20, 1'b1);
      waitBeats(8);
      checkPoly(0, 7, 1, 20);
      checkOutput("errStillSet", {31'b0, err_no_last}, 1);

      // Held output with both buffers full, then release
      $display("[TB] out_hold with both buffers full");
      resetDut();
      checkOutput("errCleared", {31'b0, err_no_last}, 0);
      beatQ.delete();
      out_hold = 1'b1;
      applyStimulus(0, 1, N, 1'b1);
      applyStimulus(10000, 1, N, 1'b1);
      checkOutput("bothFullReady", {31'b0, s_ready}, 0);
      checkOutput("holdValid", {31'b0, out_valid}, 0);
      repeat (5) tick();
      checkOutput("holdStillIdle", {31'b0, out_valid}, 0);
      checkOutput("holdNoBeats", beatQ.size(), 0);
      out_hold = 1'b0;
      tick();
      for (int k = 0; k < BEATS; k++) begin
         checkOutput($sformatf("drainReady[%0d]", k), {31'b0, s_ready}, 0);
         checkOutput($sformatf("drainBeat[%0d]", k), {29'b0, out_beat}, k);
         tick();
      end
      checkOutput("readyAfterDrain", {31'b0, s_ready}, 1);
      checkOutput("secondStart", {31'b0, out_start}, 1);
      waitBeats(16);
      checkPoly(0, 0, 1, N);
      checkPoly(8, 10000, 1, N);
      if (beatQ.size() >= 16) checkOutput("holdJoinGap", beatQ[8].cyc - beatQ[7].cyc, 1);

      // Back-to-back: second polynomial closes during final beat of the first stream
      $display("[TB] back-to-back");
      beatQ.delete();
      applyStimulus(20000, 1, N, 1'b1);
      applyStimulus(30000, 1, 8, 1'b1);
      waitBeats(16);
      checkPoly(0, 20000, 1, N);
      checkPoly(8, 30000, 1, 8);
      if (beatQ.size() >= 16) checkOutput("b2bJoinGap", beatQ[8].cyc - beatQ[7].cyc, 1);

      // Reset during beat 3 with a partial polynomial in the other buffer
      $display("[TB] reset mid-stream");
      beatQ.delete();
      applyStimulus(50000, 1, N, 1'b1);
      applyStimulus(60000, 1, 3, 1'b0);
      checkOutput("preRstBeat", {29'b0, out_beat}, 3);
      checkOutput("preRstValid", {31'b0, out_valid}, 1);
      rst = 1'b1;
      tick();
      checkOutput("midRstValid", {31'b0, out_valid}, 0);
      checkOutput("midRstStart", {31'b0, out_start}, 0);
      rst = 1'b0;
      checkOutput("postRstReady", {31'b0, s_ready}, 1);
      repeat (3) tick();
      checkOutput("abortedBeats", beatQ.size(), 4);
      beatQ.delete();
      applyStimulus(0, 1, N, 1'b1);
      waitBeats(8);
      checkPoly(0, 0, 1, N);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
